wb_writeback_unit: RTL and testbench
====================================

// Module: wb_writeback_unit
// PURPOSE
//  Write-back stage: consumes the MEM/WB pipeline register outputs and drives the GPR/FPR write ports.
//  It also owns the architectural HI/LO registers and the FP condition flag (fcc).
//  A 64-bit double FP result is split into two 32-bit writes to an even/odd FPR pair over 2 cycles.
//  It stalls the MEM/WB register for one cycle while doing so.
// PARAMETERS
//  DATA_W    64  width of MEM/WB result buses
//  WORD_W    32  register-file word width
//  REG_AW    5   register address width
//  LINK_REG  31  destination GPR for jump-and-link
// PORTS
//  clk                 in   1       clock, rising edge
//  rst_n               in   1       asynchronous active-low reset
//  MEM_WB_MemData      in   DATA_W  load data
//  MEM_WB_ALUData      in   DATA_W  ALU/FPU result
//  MEM_WB_LinkAddr     in   WORD_W  PC+8 for jump-and-link
//  MEM_WB_DstReg       in   REG_AW  GPR destination
//  MEM_WB_FP_DstReg    in   REG_AW  FPR destination
//  MEM_WB_MemtoReg     in   1       1: select MemData, 0: ALUData
//  MEM_WB_RegWrite     in   1       register write request
//  MEM_WB_JmpandLink   in   1       write LinkAddr to LINK_REG
//  MEM_WB_LoHiWrite    in   1       write HI/LO
//  MEM_WB_CompareOp    in   1       FP compare: update fcc
//  MEM_WB_floatop      in   1       destination is FPR file
//  MEM_WB_Double       in   1       FP result is double precision
//  MEM_WB_memWrite     in   1       store; suppresses all register writes
//  gpr_we/gpr_waddr/gpr_wdata  out 1/REG_AW/WORD_W  GPR write port, registered
//  fpr_we/fpr_waddr/fpr_wdata  out 1/REG_AW/WORD_W  FPR write port, registered
//  hi_q, lo_q          out  WORD_W  architectural HI/LO
//  fcc_q               out  1       FP condition flag
//  wb_stall            out  1       combinational: hold MEM/WB register this cycle
// BEHAVIOUR
//  - Reset (async, rst_n=0): all *_we=0; waddr/wdata=0; hi_q=lo_q=0; fcc_q=0; wb_stall=0; state IDLE.
//  - Result mux: res = MemtoReg ? MemData : ALUData. Write ports update 1 cycle after inputs; *_we is a 1-cycle pulse.
//  - Priority, evaluated only in IDLE:
//    memWrite > LoHiWrite > CompareOp&floatop > JmpandLink > RegWrite.
//    memWrite=1: no write of any kind.
//  - LoHiWrite: hi_q<=res[63:32], lo_q<=res[31:0]; gpr_we=fpr_we=0, even when RegWrite=1.
//  - CompareOp&floatop: fcc_q<=res[0]; no register write.
//  - JmpandLink: gpr write of LinkAddr to LINK_REG, independent of DstReg and RegWrite.
//  - RegWrite&!floatop: gpr write of res[31:0] to DstReg. DstReg==0 gives gpr_we=0.
//  - RegWrite&floatop&!Double: fpr write of res[31:0] to FP_DstReg.
//  - RegWrite&floatop&Double, FSM IDLE->DBL_HI->IDLE:
//    IDLE cycle: wb_stall=1. Next edge: fpr write res[31:0] to {FP_DstReg[4:1],0}; latch res[63:32] internally.
//    DBL_HI cycle: inputs are ignored (MEM/WB holds the same instruction); wb_stall=0.
//    Next edge: fpr write of latched high word to {FP_DstReg[4:1],1}; state returns to IDLE.
//  - wb_stall is high only in IDLE with a double FP write pending. It is never asserted in DBL_HI.
//  - Reset during DBL_HI aborts the sequence: high word is never written; state returns to IDLE.
//  - Back-to-back doubles: each takes 2 cycles; no bubble beyond the single stall.
// STRUCTURE
//  - Shared package mips_pkg: LINK_REG, WORD_W, REG_AW, wb_state_t {WB_IDLE, WB_DBL_HI}.
//  - One sub-module: wb_hilo_regs (HI/LO + fcc storage, async reset, write enables).
//  - FSM and write-port registers live in the top.
// TESTING
//  1. Reset mid-activity -> all outputs 0 immediately; state IDLE.
//  2. RegWrite=1, DstReg=5, ALUData=0x0_DEADBEEF -> next cycle gpr_we=1, waddr=5, wdata=0xDEADBEEF.
//  3. MemtoReg=1, DstReg=0, MemData=0x1234 -> gpr_we=0. Then DstReg=9 -> write 0x1234 to r9.
//  4. JmpandLink=1, LinkAddr=0x00400008, DstReg=3 -> gpr write r31=0x00400008.
//  5. Double: FP_DstReg=7, ALUData=0x3FF00000_00000001:
//     cycle0 wb_stall=1; cycle1 fpr f6=0x00000001; cycle2 fpr f7=0x3FF00000.
//     Repeat with rst_n=0 in cycle1 -> no f7 write.
//  6. LoHiWrite=1, RegWrite=1, ALUData=0xAAAA5555_12345678 -> hi_q=0xAAAA5555, lo_q=0x12345678, gpr_we=0.
//     memWrite=1 with RegWrite=1 -> no writes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the write-back stage.
package mips_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned LINK_REG = 31;

  typedef enum logic {
    WB_IDLE,
    WB_DBL_HI
  } wb_state_t;

endpackage

// File: rtl/wb_writeback_unit_if.sv
// MEM/WB pipeline register bus feeding the write-back stage, plus the stall back to MEM/WB.
interface wb_writeback_unit_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_AW = 5
);

  logic [DATA_W-1:0] MEM_WB_MemData;
  logic [DATA_W-1:0] MEM_WB_ALUData;
  logic [WORD_W-1:0] MEM_WB_LinkAddr;
  logic [REG_AW-1:0] MEM_WB_DstReg;
  logic [REG_AW-1:0] MEM_WB_FP_DstReg;
  logic              MEM_WB_MemtoReg;
  logic              MEM_WB_RegWrite;
  logic              MEM_WB_JmpandLink;
  logic              MEM_WB_LoHiWrite;
  logic              MEM_WB_CompareOp;
  logic              MEM_WB_floatop;
  logic              MEM_WB_Double;
  logic              MEM_WB_memWrite;
  logic              wb_stall;

  modport master (
    output MEM_WB_MemData, MEM_WB_ALUData, MEM_WB_LinkAddr, MEM_WB_DstReg,
           MEM_WB_FP_DstReg, MEM_WB_MemtoReg, MEM_WB_RegWrite, MEM_WB_JmpandLink,
           MEM_WB_LoHiWrite, MEM_WB_CompareOp, MEM_WB_floatop, MEM_WB_Double,
           MEM_WB_memWrite,
    input  wb_stall
  );

  modport slave (
    input  MEM_WB_MemData, MEM_WB_ALUData, MEM_WB_LinkAddr, MEM_WB_DstReg,
           MEM_WB_FP_DstReg, MEM_WB_MemtoReg, MEM_WB_RegWrite, MEM_WB_JmpandLink,
           MEM_WB_LoHiWrite, MEM_WB_CompareOp, MEM_WB_floatop, MEM_WB_Double,
           MEM_WB_memWrite,
    output wb_stall
  );

endinterface

// File: rtl/wb_writeback_unit_hilo_regs.sv
// Architectural HI/LO registers and FP condition flag owned by the write-back stage.
module wb_hilo_regs #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hilo_we,
  input  logic [WORD_W-1:0] hi_d,
  input  logic [WORD_W-1:0] lo_d,
  input  logic              fcc_we,
  input  logic              fcc_d,
  output logic [WORD_W-1:0] hi_q,
  output logic [WORD_W-1:0] lo_q,
  output logic              fcc_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      fcc_q <= 1'b0;
    end else begin
      if (hilo_we) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
      if (fcc_we) begin
        fcc_q <= fcc_d;
      end
    end
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// Write-back stage: drives GPR/FPR write ports from MEM/WB, splitting double FP results
// into an even/odd FPR pair over two cycles.
module wb_writeback_unit #(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned WORD_W   = mips_pkg::WORD_W,
  parameter int unsigned REG_AW   = mips_pkg::REG_AW,
  parameter int unsigned LINK_REG = mips_pkg::LINK_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_writeback_unit_if.slave mem_wb,
  output logic              gpr_we,
  output logic [REG_AW-1:0] gpr_waddr,
  output logic [WORD_W-1:0] gpr_wdata,
  output logic              fpr_we,
  output logic [REG_AW-1:0] fpr_waddr,
  output logic [WORD_W-1:0] fpr_wdata,
  output logic [WORD_W-1:0] hi_q,
  output logic [WORD_W-1:0] lo_q,
  output logic              fcc_q
);

  import mips_pkg::*;

  wb_state_t         state;
  logic [WORD_W-1:0] hi_word_q;
  logic [REG_AW-1:0] hi_addr_q;

  logic [DATA_W-1:0] res;
  logic              gpr_set;
  logic [REG_AW-1:0] gpr_addr_d;
  logic [WORD_W-1:0] gpr_data_d;
  logic              fpr_set;
  logic [REG_AW-1:0] fpr_addr_d;
  logic [WORD_W-1:0] fpr_data_d;
  logic              hilo_we;
  logic              fcc_we;
  logic              dbl_start;

  always_comb begin
    res        = mem_wb.MEM_WB_MemtoReg ? mem_wb.MEM_WB_MemData : mem_wb.MEM_WB_ALUData;
    gpr_set    = 1'b0;
    gpr_addr_d = '0;
    gpr_data_d = '0;
    fpr_set    = 1'b0;
    fpr_addr_d = '0;
    fpr_data_d = '0;
    hilo_we    = 1'b0;
    fcc_we     = 1'b0;
    dbl_start  = 1'b0;

    if (state == WB_DBL_HI) begin
      // MEM/WB still holds the double; only the latched high word is written.
      fpr_set    = 1'b1;
      fpr_addr_d = hi_addr_q;
      fpr_data_d = hi_word_q;
    end else if (!mem_wb.MEM_WB_memWrite) begin
      if (mem_wb.MEM_WB_LoHiWrite) begin
        hilo_we = 1'b1;
      end else if (mem_wb.MEM_WB_CompareOp && mem_wb.MEM_WB_floatop) begin
        fcc_we = 1'b1;
      end else if (mem_wb.MEM_WB_JmpandLink) begin
        gpr_set    = 1'b1;
        gpr_addr_d = REG_AW'(LINK_REG);
        gpr_data_d = mem_wb.MEM_WB_LinkAddr;
      end else if (mem_wb.MEM_WB_RegWrite && !mem_wb.MEM_WB_floatop) begin
        gpr_set    = (mem_wb.MEM_WB_DstReg != '0);
        gpr_addr_d = mem_wb.MEM_WB_DstReg;
        gpr_data_d = res[WORD_W-1:0];
      end else if (mem_wb.MEM_WB_RegWrite && !mem_wb.MEM_WB_Double) begin
        fpr_set    = 1'b1;
        fpr_addr_d = mem_wb.MEM_WB_FP_DstReg;
        fpr_data_d = res[WORD_W-1:0];
      end else if (mem_wb.MEM_WB_RegWrite) begin
        dbl_start  = 1'b1;
        fpr_set    = 1'b1;
        fpr_addr_d = {mem_wb.MEM_WB_FP_DstReg[REG_AW-1:1], 1'b0};
        fpr_data_d = res[WORD_W-1:0];
      end
    end
  end

  assign mem_wb.wb_stall = dbl_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WB_IDLE;
      hi_word_q <= '0;
      hi_addr_q <= '0;
      gpr_we    <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      fpr_we    <= 1'b0;
      fpr_waddr <= '0;
      fpr_wdata <= '0;
    end else begin
      gpr_we <= gpr_set;
      if (gpr_set) begin
        gpr_waddr <= gpr_addr_d;
        gpr_wdata <= gpr_data_d;
      end
      fpr_we <= fpr_set;
      if (fpr_set) begin
        fpr_waddr <= fpr_addr_d;
        fpr_wdata <= fpr_data_d;
      end
      case (state)
        WB_IDLE: begin
          if (dbl_start) begin
            state     <= WB_DBL_HI;
            hi_word_q <= res[2*WORD_W-1:WORD_W];
            hi_addr_q <= {mem_wb.MEM_WB_FP_DstReg[REG_AW-1:1], 1'b1};
          end
        end
        WB_DBL_HI: state <= WB_IDLE;
        default:   state <= WB_IDLE;
      endcase
    end
  end

  wb_hilo_regs #(
    .WORD_W (WORD_W)
  ) u_hilo (
    .clk     (clk),
    .rst_n   (rst_n),
    .hilo_we (hilo_we),
    .hi_d    (res[2*WORD_W-1:WORD_W]),
    .lo_d    (res[WORD_W-1:0]),
    .fcc_we  (fcc_we),
    .fcc_d   (res[0]),
    .hi_q    (hi_q),
    .lo_q    (lo_q),
    .fcc_q   (fcc_q)
  );

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench for wb_writeback_unit: expected register writes are queued at drive time.
module tb_wb_writeback_unit;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        gpr_we, fpr_we, fcc_q;
  logic [4:0]  gpr_waddr, fpr_waddr;
  logic [31:0] gpr_wdata, fpr_wdata, hi_q, lo_q;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t gq[$];
  wr_t fq[$];
  int  tests_run = 0;
  int  fails     = 0;

  always #5 clk = ~clk;

  wb_writeback_unit_if #(.DATA_W(64), .WORD_W(32), .REG_AW(5)) bus ();

  wb_writeback_unit #(
    .DATA_W   (64),
    .WORD_W   (32),
    .REG_AW   (5),
    .LINK_REG (31)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_wb    (bus),
    .gpr_we    (gpr_we),
    .gpr_waddr (gpr_waddr),
    .gpr_wdata (gpr_wdata),
    .fpr_we    (fpr_we),
    .fpr_waddr (fpr_waddr),
    .fpr_wdata (fpr_wdata),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .fcc_q     (fcc_q)
  );

  // Scoreboard consumer: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (gpr_we) begin
        tests_run++;
        if (gq.size() == 0) begin
          fails++;
          $display("FAIL gpr_unexpected: got r%0d=%h, required no write", gpr_waddr, gpr_wdata);
        end else begin
          e = gq.pop_front();
          if (gpr_waddr !== e.addr || gpr_wdata !== e.data) begin
            fails++;
            $display("FAIL gpr_write: got r%0d=%h, required r%0d=%h", gpr_waddr, gpr_wdata, e.addr, e.data);
          end
        end
      end
      if (fpr_we) begin
        tests_run++;
        if (fq.size() == 0) begin
          fails++;
          $display("FAIL fpr_unexpected: got f%0d=%h, required no write", fpr_waddr, fpr_wdata);
        end else begin
          e = fq.pop_front();
          if (fpr_waddr !== e.addr || fpr_wdata !== e.data) begin
            fails++;
            $display("FAIL fpr_write: got f%0d=%h, required f%0d=%h", fpr_waddr, fpr_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic set_idle();
    bus.MEM_WB_MemData    = '0;
    bus.MEM_WB_ALUData    = '0;
    bus.MEM_WB_LinkAddr   = '0;
    bus.MEM_WB_DstReg     = '0;
    bus.MEM_WB_FP_DstReg  = '0;
    bus.MEM_WB_MemtoReg   = 1'b0;
    bus.MEM_WB_RegWrite   = 1'b0;
    bus.MEM_WB_JmpandLink = 1'b0;
    bus.MEM_WB_LoHiWrite  = 1'b0;
    bus.MEM_WB_CompareOp  = 1'b0;
    bus.MEM_WB_floatop    = 1'b0;
    bus.MEM_WB_Double     = 1'b0;
    bus.MEM_WB_memWrite   = 1'b0;
  endtask

  task automatic push_g(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    gq.push_back(e);
  endtask

  task automatic push_f(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    fq.push_back(e);
  endtask

  task automatic test_reset();
    set_idle();
    #1;
    tests_run++;
    if ({gpr_we, fpr_we, gpr_waddr, fpr_waddr, gpr_wdata, fpr_wdata, hi_q, lo_q, fcc_q, bus.wb_stall} !== '0) begin
      fails++;
      $display("FAIL reset_state: got gpr_we=%b fpr_we=%b hi=%h lo=%h fcc=%b stall=%b, required all 0",
               gpr_we, fpr_we, hi_q, lo_q, fcc_q, bus.wb_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_gpr_alu();
    @(negedge clk);
    bus.MEM_WB_RegWrite = 1'b1;
    bus.MEM_WB_DstReg   = 5'd5;
    bus.MEM_WB_ALUData  = 64'h0_DEADBEEF;
    push_g(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    set_idle();
    tests_run++;
    if (gpr_we !== 1'b1) begin
      fails++;
      $display("FAIL gpr_alu_we: got %b, required 1", gpr_we);
    end
    @(negedge clk);
    tests_run++;
    if (gpr_we !== 1'b0 || gq.size() != 0) begin
      fails++;
      $display("FAIL gpr_alu_pulse: got we=%b pending=%0d, required we=0 pending=0", gpr_we, gq.size());
    end
  endtask

  task automatic test_mem_dst0();
    @(negedge clk);
    bus.MEM_WB_RegWrite = 1'b1;
    bus.MEM_WB_MemtoReg = 1'b1;
    bus.MEM_WB_DstReg   = 5'd0;
    bus.MEM_WB_MemData  = 64'h1234;
    bus.MEM_WB_ALUData  = 64'hFFFF_FFFF;
    @(negedge clk);
    tests_run++;
    if (gpr_we !== 1'b0) begin
      fails++;
      $display("FAIL mem_dst0: got gpr_we=%b, required 0", gpr_we);
    end
    bus.MEM_WB_DstReg = 5'd9;
    push_g(5'd9, 32'h0000_1234);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    tests_run++;
    if (gq.size() != 0) begin
      fails++;
      $display("FAIL mem_load_r9: got %0d pending writes, required 0", gq.size());
    end
  endtask

  task automatic test_jal();
    @(negedge clk);
    bus.MEM_WB_JmpandLink = 1'b1;
    bus.MEM_WB_RegWrite   = 1'b1;
    bus.MEM_WB_LinkAddr   = 32'h0040_0008;
    bus.MEM_WB_DstReg     = 5'd3;
    bus.MEM_WB_ALUData    = 64'h5555;
    push_g(5'd31, 32'h0040_0008);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    tests_run++;
    if (gq.size() != 0) begin
      fails++;
      $display("FAIL jal_link: got %0d pending writes, required 0", gq.size());
    end
  endtask

  task automatic test_fpr_single();
    @(negedge clk);
    bus.MEM_WB_RegWrite  = 1'b1;
    bus.MEM_WB_floatop   = 1'b1;
    bus.MEM_WB_FP_DstReg = 5'd13;
    bus.MEM_WB_DstReg    = 5'd4;
    bus.MEM_WB_ALUData   = 64'h1111_2222_CAFE_F00D;
    push_f(5'd13, 32'hCAFE_F00D);
    #1;
    tests_run++;
    if (bus.wb_stall !== 1'b0) begin
      fails++;
      $display("FAIL single_stall: got %b, required 0", bus.wb_stall);
    end
    @(negedge clk);
    set_idle();
    @(negedge clk);
    tests_run++;
    if (fq.size() != 0 || fpr_we !== 1'b0) begin
      fails++;
      $display("FAIL fpr_single: got pending=%0d we=%b, required pending=0 we=0", fq.size(), fpr_we);
    end
  endtask

  task automatic test_compare();
    @(negedge clk);
    bus.MEM_WB_CompareOp = 1'b1;
    bus.MEM_WB_floatop   = 1'b1;
    bus.MEM_WB_RegWrite  = 1'b1;
    bus.MEM_WB_FP_DstReg = 5'd2;
    bus.MEM_WB_ALUData   = 64'h1;
    @(negedge clk);
    tests_run++;
    if (fcc_q !== 1'b1) begin
      fails++;
      $display("FAIL fcc_set: got %b, required 1", fcc_q);
    end
    bus.MEM_WB_ALUData = 64'h2;
    @(negedge clk);
    tests_run++;
    if (fcc_q !== 1'b0) begin
      fails++;
      $display("FAIL fcc_clear: got %b, required 0", fcc_q);
    end
    // Compare without floatop falls through to an ordinary GPR write.
    bus.MEM_WB_floatop = 1'b0;
    bus.MEM_WB_DstReg  = 5'd4;
    bus.MEM_WB_ALUData = 64'h77;
    push_g(5'd4, 32'h77);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    tests_run++;
    if (fcc_q !== 1'b0 || gq.size() != 0) begin
      fails++;
      $display("FAIL cmp_int: got fcc=%b pending=%0d, required fcc=0 pending=0", fcc_q, gq.size());
    end
  endtask

  task automatic drive_double(input logic [4:0] fd, input logic [63:0] v);
    bus.MEM_WB_RegWrite  = 1'b1;
    bus.MEM_WB_floatop   = 1'b1;
    bus.MEM_WB_Double    = 1'b1;
    bus.MEM_WB_FP_DstReg = fd;
    bus.MEM_WB_ALUData   = v;
  endtask

  task automatic test_double();
    @(negedge clk);
    drive_double(5'd7, 64'h3FF0_0000_0000_0001);
    push_f(5'd6, 32'h0000_0001);
    push_f(5'd7, 32'h3FF0_0000);
    #1;
    tests_run++;
    if (bus.wb_stall !== 1'b1) begin
      fails++;
      $display("FAIL dbl_stall0: got %b, required 1", bus.wb_stall);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.wb_stall !== 1'b0 || fpr_we !== 1'b1 || fpr_waddr !== 5'd6) begin
      fails++;
      $display("FAIL dbl_cycle1: got stall=%b we=%b addr=%0d, required stall=0 we=1 addr=6",
               bus.wb_stall, fpr_we, fpr_waddr);
    end
    @(negedge clk);
    set_idle();
    tests_run++;
    if (fpr_we !== 1'b1 || fpr_waddr !== 5'd7) begin
      fails++;
      $display("FAIL dbl_cycle2: got we=%b addr=%0d, required we=1 addr=7", fpr_we, fpr_waddr);
    end
    @(negedge clk);
    tests_run++;
    if (fpr_we !== 1'b0 || fq.size() != 0) begin
      fails++;
      $display("FAIL dbl_done: got we=%b pending=%0d, required we=0 pending=0", fpr_we, fq.size());
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_double(5'd3, 64'hAAAA_0001_BBBB_0002);
    push_f(5'd2, 32'hBBBB_0002);
    push_f(5'd3, 32'hAAAA_0001);
    push_f(5'd10, 32'hDDDD_0004);
    push_f(5'd11, 32'hCCCC_0003);
    #1;
    tests_run++;
    if (bus.wb_stall !== 1'b1) begin
      fails++;
      $display("FAIL b2b_stall_a: got %b, required 1", bus.wb_stall);
    end
    @(negedge clk);
    @(negedge clk);
    drive_double(5'd10, 64'hCCCC_0003_DDDD_0004);
    #1;
    tests_run++;
    if (bus.wb_stall !== 1'b1) begin
      fails++;
      $display("FAIL b2b_stall_b: got %b, required 1", bus.wb_stall);
    end
    @(negedge clk);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    tests_run++;
    if (fq.size() != 0) begin
      fails++;
      $display("FAIL b2b_done: got %0d pending writes, required 0", fq.size());
    end
  endtask

  task automatic test_double_reset();
    @(negedge clk);
    drive_double(5'd7, 64'h3FF0_0000_0000_0001);
    push_f(5'd6, 32'h0000_0001);
    @(negedge clk);
    #2;
    set_idle();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({gpr_we, fpr_we, fpr_waddr, fpr_wdata, bus.wb_stall} !== '0) begin
      fails++;
      $display("FAIL dbl_reset: got fpr_we=%b addr=%0d data=%h stall=%b, required all 0",
               fpr_we, fpr_waddr, fpr_wdata, bus.wb_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.MEM_WB_RegWrite  = 1'b1;
    bus.MEM_WB_floatop   = 1'b1;
    bus.MEM_WB_FP_DstReg = 5'd20;
    bus.MEM_WB_ALUData   = 64'h55;
    push_f(5'd20, 32'h55);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    tests_run++;
    if (fq.size() != 0) begin
      fails++;
      $display("FAIL dbl_reset_idle: got %0d pending writes, required 0", fq.size());
    end
  endtask

  task automatic test_hilo();
    @(negedge clk);
    bus.MEM_WB_LoHiWrite = 1'b1;
    bus.MEM_WB_RegWrite  = 1'b1;
    bus.MEM_WB_DstReg    = 5'd8;
    bus.MEM_WB_ALUData   = 64'hAAAA_5555_1234_5678;
    @(negedge clk);
    set_idle();
    tests_run++;
    if (hi_q !== 32'hAAAA_5555 || lo_q !== 32'h1234_5678 || gpr_we !== 1'b0 || fpr_we !== 1'b0) begin
      fails++;
      $display("FAIL hilo: got hi=%h lo=%h gpr_we=%b fpr_we=%b, required hi=aaaa5555 lo=12345678 we=0",
               hi_q, lo_q, gpr_we, fpr_we);
    end
  endtask

  task automatic test_memwrite();
    @(negedge clk);
    bus.MEM_WB_memWrite  = 1'b1;
    bus.MEM_WB_RegWrite  = 1'b1;
    bus.MEM_WB_LoHiWrite = 1'b1;
    bus.MEM_WB_DstReg    = 5'd10;
    bus.MEM_WB_ALUData   = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    tests_run++;
    if (gpr_we !== 1'b0 || hi_q !== 32'hAAAA_5555 || lo_q !== 32'h1234_5678) begin
      fails++;
      $display("FAIL memwrite_hold: got gpr_we=%b hi=%h lo=%h, required we=0 hi=aaaa5555 lo=12345678",
               gpr_we, hi_q, lo_q);
    end
    bus.MEM_WB_LoHiWrite = 1'b0;
    bus.MEM_WB_floatop   = 1'b1;
    bus.MEM_WB_Double    = 1'b1;
    #1;
    tests_run++;
    if (bus.wb_stall !== 1'b0) begin
      fails++;
      $display("FAIL memwrite_stall: got %b, required 0", bus.wb_stall);
    end
    @(negedge clk);
    set_idle();
    tests_run++;
    if (fpr_we !== 1'b0 || gpr_we !== 1'b0) begin
      fails++;
      $display("FAIL memwrite_fpr: got fpr_we=%b gpr_we=%b, required 0", fpr_we, gpr_we);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.MEM_WB_RegWrite = 1'b1;
    bus.MEM_WB_DstReg   = 5'd6;
    bus.MEM_WB_ALUData  = 64'h99;
    push_g(5'd6, 32'h99);
    @(negedge clk);
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({gpr_we, fpr_we, gpr_waddr, gpr_wdata, fpr_waddr, fpr_wdata, hi_q, lo_q, fcc_q, bus.wb_stall} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got gpr_we=%b addr=%0d data=%h hi=%h lo=%h fcc=%b, required all 0",
               gpr_we, gpr_waddr, gpr_wdata, hi_q, lo_q, fcc_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_gpr_alu();
    test_mem_dst0();
    test_jal();
    test_fpr_single();
    test_compare();
    test_double();
    test_back_to_back();
    test_double_reset();
    test_hilo();
    test_memwrite();
    test_reset_mid();
    @(negedge clk);
    tests_run++;
    if (gq.size() != 0 || fq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got gpr=%0d fpr=%0d pending, required 0", gq.size(), fq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
